clkdiv: RTL and testbench

CLKDIV -- requirements
Module: clkdiv

---
 rtl/clkdiv.sv | 118 +++++++++++
 tb/tb_clkdiv.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clkdiv.sv
// Programmable integer clock divider with a glitch-free registered output and
// a ready/valid ratio-change port. New ratios only take effect on period boundaries.
module clkdiv #(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned DIV_INIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             div_valid_i,
   output logic             div_ready_o,
   output logic             clk_out,
   output logic             tick_o,
   output logic [DIV_W-1:0] ratio_o
);

   localparam int unsigned INIT_H = (DIV_INIT + 1) / 2;

   typedef enum logic [1:0] {RUN, PEND, STOP} state_t;

   // high-phase length: ceil(n/2), computed one bit wider to survive n = 2^DIV_W-1
   function automatic logic [DIV_W-1:0] f_half(input logic [DIV_W-1:0] n);
      logic [DIV_W:0] t;
      t = {1'b0, n} + (DIV_W+1)'(1);
      return DIV_W'(t >> 1);
   endfunction

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
   logic [DIV_W-1:0] r_n, w_n_nxt;
   logic [DIV_W-1:0] r_h, w_h_nxt;
   logic [DIV_W-1:0] r_pend, w_pend_nxt;
   logic             r_pend_vld, w_pend_vld_nxt;
   logic             r_ready, w_ready_nxt;
   logic             r_clk_out, w_clk_out_nxt;
   logic             r_tick, w_tick_nxt;

   logic w_wrap;
   logic w_bound;
   logic w_accept;

   assign w_wrap   = (r_cnt == r_n - DIV_W'(1));
   assign w_bound  = (r_state == STOP) || w_wrap;
   assign w_accept = div_valid_i && r_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_cnt      <= DIV_W'(DIV_INIT - 1);
         r_n        <= DIV_W'(DIV_INIT);
         r_h        <= DIV_W'(INIT_H);
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_ready    <= 1'b1;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_n        <= w_n_nxt;
         r_h        <= w_h_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_ready    <= w_ready_nxt;
         r_clk_out  <= w_clk_out_nxt;
         r_tick     <= w_tick_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_n_nxt        = r_n;
      w_h_nxt        = r_h;
      w_pend_nxt     = r_pend;
      w_pend_vld_nxt = r_pend_vld;
      w_clk_out_nxt  = r_clk_out;
      w_tick_nxt     = 1'b0;

      // only a request pending from an earlier edge may be applied here
      if (w_bound && r_pend_vld) begin
         w_n_nxt        = r_pend;
         w_h_nxt        = f_half(r_pend);
         w_pend_vld_nxt = 1'b0;
      end

      if (w_accept) begin
         w_pend_nxt     = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
         w_pend_vld_nxt = 1'b1;
      end

      if (w_bound) begin
         if (en_i) begin
            w_cnt_nxt     = '0;
            w_clk_out_nxt = 1'b1;
            w_tick_nxt    = 1'b1;
            w_state_nxt   = w_pend_vld_nxt ? PEND : RUN;
         end else begin
            w_cnt_nxt     = w_n_nxt - DIV_W'(1);
            w_clk_out_nxt = 1'b0;
            w_state_nxt   = STOP;
         end
      end else begin
         w_cnt_nxt     = r_cnt + DIV_W'(1);
         w_clk_out_nxt = (r_cnt + DIV_W'(1)) < r_h;
         w_state_nxt   = w_pend_vld_nxt ? PEND : RUN;
      end

      w_ready_nxt = !w_pend_vld_nxt;
   end

   assign div_ready_o = r_ready;
   assign clk_out     = r_clk_out;
   assign tick_o      = r_tick;
   assign ratio_o     = r_n;

endmodule

// File: tb/tb_clkdiv.sv
// Randomized self-checking bench for clkdiv; a period-level reference model
// builds each period's waveform as a queue of expected clk_out bits.
module tb_clkdiv;

   localparam int unsigned DIV_W    = 8;
   localparam int unsigned DIV_INIT = 4;
   localparam int          N_CYC    = 3000;

   logic             clk = 1'b0;
   logic             rst;
   logic             en_i;
   logic [DIV_W-1:0] div_i;
   logic             div_valid_i;
   logic             div_ready_o;
   logic             clk_out;
   logic             tick_o;
   logic [DIV_W-1:0] ratio_o;

   int n_checks = 0;
   int n_errs   = 0;

   clkdiv #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i),
      .div_i      (div_i),
      .div_valid_i(div_valid_i),
      .div_ready_o(div_ready_o),
      .clk_out    (clk_out),
      .tick_o     (tick_o),
      .ratio_o    (ratio_o)
   );

   always #5 clk = ~clk;

   // reference model state
   bit m_q[$];
   int m_n;
   int m_pend;
   bit m_pend_vld;
   bit m_ready;
   bit m_clk;
   bit m_tick;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_n        = DIV_INIT;
      m_pend     = 0;
      m_pend_vld = 1'b0;
      m_ready    = 1'b1;
      m_clk      = 1'b0;
      m_tick     = 1'b0;
   endtask

   // one rising edge of clk, using the inputs presented before the edge
   task automatic model_step();
      bit acc;
      acc = div_valid_i && m_ready;
      if (m_q.size() == 0) begin
         if (m_pend_vld) begin
            m_n        = m_pend;
            m_pend_vld = 1'b0;
         end
         if (en_i) begin
            for (int k = 0; k < m_n; k++) m_q.push_back(k < (m_n + 1) / 2);
            m_clk  = m_q.pop_front();
            m_tick = 1'b1;
         end else begin
            m_clk  = 1'b0;
            m_tick = 1'b0;
         end
      end else begin
         m_clk  = m_q.pop_front();
         m_tick = 1'b0;
      end
      if (acc) begin
         m_pend     = (int'(div_i) < 2) ? 2 : int'(div_i);
         m_pend_vld = 1'b1;
      end
      m_ready = !m_pend_vld;
   endtask

   task automatic compare_all();
      check("clk_out", 32'(clk_out), 32'(m_clk));
      check("tick_o", 32'(tick_o), 32'(m_tick));
      check("div_ready_o", 32'(div_ready_o), 32'(m_ready));
      check("ratio_o", 32'(ratio_o), 32'(m_n));
   endtask

   task automatic drive_random();
      if ($urandom_range(0, 11) == 0) en_i = ~en_i;
      div_valid_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) div_i = DIV_W'($urandom_range(0, 1));
      else                           div_i = DIV_W'($urandom_range(2, 10));
   endtask

   initial begin
      bit pend_rst_done;
      int rst_hold;
      pend_rst_done = 1'b0;
      rst_hold      = 0;
      rst           = 1'b1;
      en_i          = 1'b1;
      div_i         = '0;
      div_valid_i   = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick_o), 32'd0);
      check("rst_ready", 32'(div_ready_o), 32'd1);
      check("rst_ratio", 32'(ratio_o), 32'(DIV_INIT));
      rst = 1'b0;

      for (int i = 0; i < N_CYC; i++) begin
         @(posedge clk);
         if (!rst) model_step();
         @(negedge clk);
         compare_all();
         if (rst) begin
            if (rst_hold > 0) rst_hold--;
            else rst = 1'b0;
         end else if (i == 700 || (i > 1500 && m_pend_vld && !pend_rst_done)) begin
            if (i > 1500) pend_rst_done = 1'b1;
            rst         = 1'b1;
            div_valid_i = 1'b0;
            #1;
            check("async_rst_clk_out", 32'(clk_out), 32'd0);
            check("async_rst_tick", 32'(tick_o), 32'd0);
            check("async_rst_ready", 32'(div_ready_o), 32'd1);
            check("async_rst_ratio", 32'(ratio_o), 32'(DIV_INIT));
            model_reset();
            rst_hold = 1;
         end else if (i < 12) begin
            en_i        = 1'b1;
            div_valid_i = 1'b0;
         end else begin
            drive_random();
         end
      end

      check("pend_rst_exercised", 32'(pend_rst_done), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
